// File: rtl/spi_txn_ctrl_if.sv
// Bus bundle for spi_txn_ctrl: transaction control, upstream TX stream,
// RX return and the byte-master side of the link.
//   slave  : the transaction controller's view
//   master : the surrounding SoC / byte-master view (driver of the inputs)
// Signal names keep the i_/o_ direction prefixes as seen from the controller.
interface spi_txn_ctrl_if #(
  parameter int unsigned MAX_BYTES = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_BYTES + 1);

  // Transaction control
  logic             i_Start;
  logic [LEN_W-1:0] i_Len;
  logic             o_Busy;
  logic             o_Done;

  // Upstream TX stream and RX return
  logic [7:0]       i_TX_Byte;
  logic             i_TX_Valid;
  logic             o_TX_Ready;
  logic [7:0]       o_RX_Byte;
  logic             o_RX_Valid;

  // Byte master link and chip select
  logic [7:0]       o_M_TX_Byte;
  logic             o_M_TX_DV;
  logic             i_M_TX_Ready;
  logic             i_M_RX_DV;
  logic [7:0]       i_M_RX_Byte;
  logic             o_SPI_CS_n;

  modport slave (
    input  i_Start, i_Len, i_TX_Byte, i_TX_Valid,
           i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    output o_Busy, o_Done, o_TX_Ready, o_RX_Byte, o_RX_Valid,
           o_M_TX_Byte, o_M_TX_DV, o_SPI_CS_n
  );

  modport master (
    output i_Start, i_Len, i_TX_Byte, i_TX_Valid,
           i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    input  o_Busy, o_Done, o_TX_Ready, o_RX_Byte, o_RX_Valid,
           o_M_TX_Byte, o_M_TX_DV, o_SPI_CS_n
  );
endinterface

// File: rtl/spi_txn_ctrl.sv
// Multi-byte SPI transaction sequencer in front of a byte-level SPI master.
// Drives CS_n with programmable setup/hold/gap times, feeds upstream TX bytes
// into the byte master's DV/Ready handshake and returns RX bytes as pulses.
// Ports:
//   i_Clk  : system clock, shared with the byte master
//   i_Rst  : synchronous active-high reset
//   bus    : spi_txn_ctrl_if.slave (start/len/busy/done, TX stream, RX return,
//            byte-master link, CS_n). All outputs are registered except
//            o_TX_Ready, which is a combinational pass-through of the master's
//            ready while waiting to load a byte.
// The byte master must be reset in the same cycle (drive its rst_n with ~i_Rst).
module spi_txn_ctrl #(
  parameter int unsigned MAX_BYTES     = 16,
  parameter int unsigned CS_SETUP_CLKS = 2,
  parameter int unsigned CS_HOLD_CLKS  = 2,
  parameter int unsigned CS_GAP_CLKS   = 2
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  spi_txn_ctrl_if.slave bus
);

  localparam int unsigned LEN_W      = $clog2(MAX_BYTES + 1);
  localparam int unsigned DLY_MAX_SH = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int unsigned DLY_MAX    = (DLY_MAX_SH > CS_GAP_CLKS) ? DLY_MAX_SH : CS_GAP_CLKS;
  localparam int unsigned DLY_W      = $clog2(DLY_MAX + 1);

  localparam logic [DLY_W-1:0] SETUP_LD = DLY_W'(CS_SETUP_CLKS);
  localparam logic [DLY_W-1:0] HOLD_LD  = DLY_W'(CS_HOLD_CLKS);
  localparam logic [DLY_W-1:0] GAP_LD   = DLY_W'(CS_GAP_CLKS);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_XFER  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  state_e           state_q,     state_d;
  logic [LEN_W-1:0] rem_q,       rem_d;
  logic [DLY_W-1:0] dly_q,       dly_d;
  logic             cs_n_q,      cs_n_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             rx_valid_q,  rx_valid_d;
  logic [7:0]       rx_byte_q,   rx_byte_d;
  logic             m_tx_dv_q,   m_tx_dv_d;
  logic [7:0]       m_tx_byte_q, m_tx_byte_d;

  logic             tx_ready_c;
  logic             tx_hs_c;

  // Upstream may only hand over a byte while loading and the master is ready
  assign tx_ready_c = (state_q == ST_LOAD) && bus.i_M_TX_Ready;
  assign tx_hs_c    = tx_ready_c && bus.i_TX_Valid;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dly_d       = dly_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    m_tx_dv_d   = 1'b0;
    m_tx_byte_d = m_tx_byte_q;

    unique case (state_q)
      ST_IDLE: begin
        // Zero-length requests are dropped without touching CS_n
        if (bus.i_Start && (bus.i_Len != '0)) begin
          rem_d   = bus.i_Len;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          dly_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        dly_d = dly_q - DLY_ONE;
        if (dly_q == DLY_ONE) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // CS_n stays low for as long as upstream withholds data
        if (tx_hs_c) begin
          m_tx_byte_d = bus.i_TX_Byte;
          m_tx_dv_d   = 1'b1;
          state_d     = ST_XFER;
        end
      end

      ST_XFER: begin
        if (bus.i_M_RX_DV) begin
          rx_byte_d  = bus.i_M_RX_Byte;
          rx_valid_d = 1'b1;
          rem_d      = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            dly_d   = HOLD_LD;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_HOLD: begin
        dly_d = dly_q - DLY_ONE;
        if (dly_q == DLY_ONE) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          dly_d   = GAP_LD;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        // Busy stays high here so a new start cannot shorten the CS_n-high gap
        dly_d = dly_q - DLY_ONE;
        if (dly_q == DLY_ONE) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      dly_q       <= '0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= 8'h00;
      m_tx_dv_q   <= 1'b0;
      m_tx_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dly_q       <= dly_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rx_valid_q  <= rx_valid_d;
      rx_byte_q   <= rx_byte_d;
      m_tx_dv_q   <= m_tx_dv_d;
      m_tx_byte_q <= m_tx_byte_d;
    end
  end

  assign bus.o_Busy      = busy_q;
  assign bus.o_Done      = done_q;
  assign bus.o_TX_Ready  = tx_ready_c;
  assign bus.o_RX_Byte   = rx_byte_q;
  assign bus.o_RX_Valid  = rx_valid_q;
  assign bus.o_M_TX_Byte = m_tx_byte_q;
  assign bus.o_M_TX_DV   = m_tx_dv_q;
  assign bus.o_SPI_CS_n  = cs_n_q;

endmodule
